// File: rtl/arb_out_buffer.sv
// Elastic output buffer between the arbiter and the readout FIFO, with word/loss counters.
// Optional feature: define ARB_OUT_MARKER_EN to insert a loss-marker word after an overflow episode.
module arb_out_buffer #(
   parameter int DEPTH_LOG2   = 4,
   parameter int READY_MARGIN = 3
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST,
   input  logic        ARB_WRITE_IN,
   input  logic [31:0] ARB_DATA_IN,
   output logic        ARB_READY_OUT,
   input  logic        FIFO_FULL,
   input  logic        FIFO_NEAR_FULL,
   output logic        FIFO_WRITE,
   output logic [31:0] FIFO_DATA,
   input  logic        CLEAR_CNT,
   output logic [31:0] WORD_CNT,
   output logic [15:0] LOST_CNT,
   output logic        OVERFLOW
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FILL_MAX    = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] READY_LIMIT = (DEPTH_LOG2+1)'(DEPTH - READY_MARGIN);

`ifdef ARB_OUT_MARKER_EN
   typedef enum logic [1:0] {ACCEPT, BLOCKED, MARK} state_t;
`else
   typedef enum logic [1:0] {ACCEPT, BLOCKED} state_t;
`endif

   state_t state, state_next;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   fill, fill_next;
   logic                  full, empty, pop, push, drop, in_mark, mark_next;
   logic [31:0]           push_data;

   assign full  = (fill == FILL_MAX);
   assign empty = (fill == '0);
   assign pop   = !empty && !FIFO_FULL;

`ifdef ARB_OUT_MARKER_EN
   logic drop_seen;

   assign in_mark   = (state == MARK);
   assign mark_next = (state_next == MARK);
   assign push_data = in_mark ? {4'hF, 12'h000, LOST_CNT} : ARB_DATA_IN;
`else
   assign in_mark   = 1'b0;
   assign mark_next = 1'b0;
   assign push_data = ARB_DATA_IN;
`endif

   // While marking, the buffer slot belongs to the marker, so any arbiter word is lost
   assign push      = !full && (ARB_WRITE_IN || in_mark);
   assign drop      = ARB_WRITE_IN && (full || in_mark);
   assign fill_next = fill + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

   always_comb begin
      state_next = state;
      case (state)
         ACCEPT: begin
            if (fill_next == FILL_MAX) state_next = BLOCKED;
         end
         BLOCKED: begin
            if (fill_next != FILL_MAX && !drop) begin
`ifdef ARB_OUT_MARKER_EN
               state_next = drop_seen ? MARK : ACCEPT;
`else
               state_next = ACCEPT;
`endif
            end
         end
`ifdef ARB_OUT_MARKER_EN
         MARK: begin
            if (push) state_next = (fill_next == FILL_MAX) ? BLOCKED : ACCEPT;
         end
`endif
         default: state_next = ACCEPT;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (push) mem[wr_ptr] <= push_data;
   end

`ifdef ARB_OUT_MARKER_EN
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST)                        drop_seen <= 1'b0;
      else if (state == BLOCKED && drop)  drop_seen <= 1'b1;
      else if (state_next != BLOCKED)     drop_seen <= 1'b0;
   end
`endif

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill          <= '0;
         state         <= ACCEPT;
         ARB_READY_OUT <= 1'b0;
         FIFO_WRITE    <= 1'b0;
         FIFO_DATA     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
            FIFO_DATA <= mem[rd_ptr];
         end
         fill          <= fill_next;
         state         <= state_next;
         FIFO_WRITE    <= pop;
         ARB_READY_OUT <= !FIFO_NEAR_FULL && (fill_next <= READY_LIMIT) && !mark_next;
      end
   end

   // A clear request takes priority over any increment in the same cycle
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST || CLEAR_CNT) begin
         WORD_CNT <= '0;
         LOST_CNT <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (pop) WORD_CNT <= WORD_CNT + 32'd1;
         if (drop && LOST_CNT != 16'hFFFF) LOST_CNT <= LOST_CNT + 16'd1;
         if (drop) OVERFLOW <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arb_out_buffer.sv
// Scoreboard testbench for arb_out_buffer: stimulus pushes expected words, a monitor checks deliveries.
module tb_arb_out_buffer;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b1;
   logic        ARB_WRITE_IN = 1'b0;
   logic [31:0] ARB_DATA_IN = '0;
   logic        FIFO_FULL = 1'b0;
   logic        FIFO_NEAR_FULL = 1'b0;
   logic        CLEAR_CNT = 1'b0;
   logic        ARB_READY_OUT;
   logic        FIFO_WRITE;
   logic [31:0] FIFO_DATA;
   logic [31:0] WORD_CNT;
   logic [15:0] LOST_CNT;
   logic        OVERFLOW;

   int checks = 0;
   int errors = 0;
   logic [31:0] expq [$];

`ifdef ARB_OUT_MARKER_EN
   localparam int MARK_WORDS = 1;
`else
   localparam int MARK_WORDS = 0;
`endif

   arb_out_buffer dut (
      .BUS_CLK        (BUS_CLK),
      .BUS_RST        (BUS_RST),
      .ARB_WRITE_IN   (ARB_WRITE_IN),
      .ARB_DATA_IN    (ARB_DATA_IN),
      .ARB_READY_OUT  (ARB_READY_OUT),
      .FIFO_FULL      (FIFO_FULL),
      .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
      .FIFO_WRITE     (FIFO_WRITE),
      .FIFO_DATA      (FIFO_DATA),
      .CLEAR_CNT      (CLEAR_CNT),
      .WORD_CNT       (WORD_CNT),
      .LOST_CNT       (LOST_CNT),
      .OVERFLOW       (OVERFLOW)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge BUS_CLK);
   endtask

   task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic expect_out);
      ARB_WRITE_IN = wr;
      ARB_DATA_IN  = data;
      if (wr && expect_out) expq.push_back(data);
      tick();
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout actual=%0d words left required=0", expq.size());
         expq.delete();
      end
      repeat (2) tick();
   endtask

   // Monitor: every delivered word must be the oldest outstanding expected word
   always @(negedge BUS_CLK) begin
      if (FIFO_WRITE === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual=%h required=no write", FIFO_DATA);
         end else begin
            checkOutput("fifo_data", FIFO_DATA, expq.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state and release
      repeat (3) tick();
      sample();
      checkOutput("rst_fifo_write", 32'(FIFO_WRITE), 32'd0);
      checkOutput("rst_ready", 32'(ARB_READY_OUT), 32'd0);
      checkOutput("rst_word_cnt", WORD_CNT, 32'd0);
      checkOutput("rst_lost_cnt", 32'(LOST_CNT), 32'd0);
      checkOutput("rst_overflow", 32'(OVERFLOW), 32'd0);
      checkOutput("rst_fifo_data", FIFO_DATA, 32'd0);
      tick();
      BUS_RST = 1'b0;
      sample();
      checkOutput("ready_before_edge", 32'(ARB_READY_OUT), 32'd0);
      tick();
      sample();
      checkOutput("ready_after_release", 32'(ARB_READY_OUT), 32'd1);

      // Single word latency: accepted at edge N, delivered at edge N+1
      tick();
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
      ARB_WRITE_IN = 1'b0;
      sample();
      checkOutput("latency_n1", 32'(FIFO_WRITE), 32'd0);
      tick();
      sample();
      checkOutput("latency_n2", 32'(FIFO_WRITE), 32'd1);
      checkOutput("word_cnt_one", WORD_CNT, 32'd1);

      // Sustained back-to-back stream
      tick();
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
      ARB_WRITE_IN = 1'b0;
      waitDrain(30);
      checkOutput("word_cnt_stream", WORD_CNT, 32'd7);

      // Downstream near-full throttles the arbiter
      FIFO_NEAR_FULL = 1'b1;
      tick();
      sample();
      checkOutput("ready_near_full", 32'(ARB_READY_OUT), 32'd0);
      FIFO_NEAR_FULL = 1'b0;
      tick();
      sample();
      checkOutput("ready_near_full_off", 32'(ARB_READY_OUT), 32'd1);

      // Overflow burst with blocked downstream: 16 stored, 4 dropped
      tick();
      FIFO_FULL = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 32'h0000_0100 + 32'(i), i < 16);
         sample();
         checkOutput("ready_vs_fill", 32'(ARB_READY_OUT), (i + 1 <= 13) ? 32'd1 : 32'd0);
      end
      ARB_WRITE_IN = 1'b0;
      tick();
      sample();
      checkOutput("burst_lost_cnt", 32'(LOST_CNT), 32'd4);
      checkOutput("burst_overflow", 32'(OVERFLOW), 32'd1);
      checkOutput("burst_no_write", 32'(FIFO_WRITE), 32'd0);
      if (MARK_WORDS != 0) expq.push_back(32'hF000_0004);
      tick();
      FIFO_FULL = 1'b0;
      waitDrain(60);
      checkOutput("burst_word_cnt", WORD_CNT, 32'(7 + 16 + MARK_WORDS));
      sample();
      checkOutput("ready_after_drain", 32'(ARB_READY_OUT), 32'd1);

      // Clear in the same cycle as a drop wins over the drop accounting
      tick();
      FIFO_FULL = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h0000_0200 + 32'(i), 1'b1);
      CLEAR_CNT = 1'b1;
      applyStimulus(1'b1, 32'h0000_02FF, 1'b0);
      CLEAR_CNT = 1'b0;
      ARB_WRITE_IN = 1'b0;
      sample();
      checkOutput("clear_lost_cnt", 32'(LOST_CNT), 32'd0);
      checkOutput("clear_overflow", 32'(OVERFLOW), 32'd0);
      checkOutput("clear_word_cnt", WORD_CNT, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h0000_03FF, 1'b0);
      ARB_WRITE_IN = 1'b0;
      sample();
      checkOutput("drop_after_clear_lost", 32'(LOST_CNT), 32'd1);
      checkOutput("drop_after_clear_ovf", 32'(OVERFLOW), 32'd1);
      if (MARK_WORDS != 0) expq.push_back(32'hF000_0001);
      tick();
      FIFO_FULL = 1'b0;
      waitDrain(60);
      checkOutput("clear_drain_word_cnt", WORD_CNT, 32'(16 + MARK_WORDS));

      // Reset with 8 words buffered discards them
      FIFO_FULL = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h0000_0400 + 32'(i), 1'b0);
      ARB_WRITE_IN = 1'b0;
      BUS_RST = 1'b1;
      repeat (2) tick();
      FIFO_FULL = 1'b0;
      BUS_RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         sample();
         checkOutput("post_rst_no_write", 32'(FIFO_WRITE), 32'd0);
      end
      checkOutput("post_rst_lost_cnt", 32'(LOST_CNT), 32'd0);
      tick();
      applyStimulus(1'b1, 32'h0000_0001, 1'b1);
      ARB_WRITE_IN = 1'b0;
      waitDrain(20);
      checkOutput("post_rst_word_cnt", WORD_CNT, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
